// File: rtl/fighter_anim_pkg.sv
// Shared definitions for the fighter animation controller: code map, states, hold default.
package fighter_anim_pkg;

    localparam int unsigned ANIM_W       = 6;
    localparam int unsigned HOLD_W       = 4;
    localparam int unsigned HOLD_DEFAULT = 6;

    // Animation codes driving the sprite color mapper select input
    localparam logic [ANIM_W-1:0] A_START     = 6'd0;
    localparam logic [ANIM_W-1:0] A_IDLE_0    = 6'd1;
    localparam logic [ANIM_W-1:0] A_IDLE_1    = 6'd2;
    localparam logic [ANIM_W-1:0] A_IDLE_2    = 6'd3;
    localparam logic [ANIM_W-1:0] A_WALK_IN   = 6'd4;
    localparam logic [ANIM_W-1:0] A_WALK_0    = 6'd5;
    localparam logic [ANIM_W-1:0] A_WALK_1    = 6'd6;
    localparam logic [ANIM_W-1:0] A_WALK_2    = 6'd7;
    localparam logic [ANIM_W-1:0] A_PUNCH_0   = 6'd8;
    localparam logic [ANIM_W-1:0] A_PUNCH_1   = 6'd9;
    localparam logic [ANIM_W-1:0] A_PUNCH_2   = 6'd10;
    localparam logic [ANIM_W-1:0] A_PUNCH_3   = 6'd11;
    localparam logic [ANIM_W-1:0] A_STUN_0    = 6'd12;
    localparam logic [ANIM_W-1:0] A_STUN_1    = 6'd13;
    localparam logic [ANIM_W-1:0] A_STUN_2    = 6'd14;
    localparam logic [ANIM_W-1:0] A_STUN_3    = 6'd15;
    localparam logic [ANIM_W-1:0] A_KICK_0    = 6'd16;
    localparam logic [ANIM_W-1:0] A_KICK_1    = 6'd17;
    localparam logic [ANIM_W-1:0] A_KICK_2    = 6'd18;
    localparam logic [ANIM_W-1:0] A_KICK_3    = 6'd19;
    localparam logic [ANIM_W-1:0] A_CROUCH    = 6'd20;
    localparam logic [ANIM_W-1:0] A_CKICK_0   = 6'd21;
    localparam logic [ANIM_W-1:0] A_CKICK_1   = 6'd22;
    localparam logic [ANIM_W-1:0] A_CKICK_2   = 6'd23;
    localparam logic [ANIM_W-1:0] A_JUMP_0    = 6'd24;
    localparam logic [ANIM_W-1:0] A_JUMP_1    = 6'd25;
    localparam logic [ANIM_W-1:0] A_JUMP_2    = 6'd26;
    localparam logic [ANIM_W-1:0] A_JUMP_3    = 6'd27;
    localparam logic [ANIM_W-1:0] A_JUMP_4    = 6'd28;
    localparam logic [ANIM_W-1:0] A_SPECIAL_0 = 6'd29;
    localparam logic [ANIM_W-1:0] A_SPECIAL_1 = 6'd30;
    localparam logic [ANIM_W-1:0] A_SPECIAL_2 = 6'd31;
    localparam logic [ANIM_W-1:0] A_SPECIAL_3 = 6'd32;
    localparam logic [ANIM_W-1:0] A_KO_0      = 6'd33;
    localparam logic [ANIM_W-1:0] A_KO_1      = 6'd34;
    localparam logic [ANIM_W-1:0] A_KO_2      = 6'd35;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WALK,
        ST_CROUCH,
        ST_PUNCH,
        ST_KICK,
        ST_CKICK,
        ST_JUMP,
        ST_SPECIAL,
        ST_HITSTUN,
        ST_KO
    } anim_state_t;

    // Frames in which the hitbox is live
    function automatic logic is_attack_code(input logic [ANIM_W-1:0] code);
        return (code == A_PUNCH_2) || (code == A_KICK_2) || (code == A_CKICK_1) ||
               (code == A_SPECIAL_2) || (code == A_SPECIAL_3);
    endfunction

    // Every state outside the interruptible ones is a committed sequence
    function automatic logic is_busy_state(input anim_state_t st);
        return !((st == ST_IDLE) || (st == ST_WALK) || (st == ST_CROUCH));
    endfunction

endpackage

// File: rtl/fighter_anim_ctrl_anim_step_timer.sv
// Hold counter: counts frame ticks and flags the tick that ends a hold period.
module anim_step_timer
    import fighter_anim_pkg::*;
#(
    parameter int unsigned HOLD = HOLD_DEFAULT
)
(
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_tick,
    input  logic clear,
    output logic step_c
);

    localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD - 1);

    logic [HOLD_W-1:0] count;

    assign step_c = frame_tick && (count == LAST);

    // Count ticks; wrap at end of period, clear on immediate events
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (clear || step_c) begin
            count <= '0;
        end else if (frame_tick) begin
            count <= count + HOLD_W'(1);
        end
    end

endmodule

// File: rtl/fighter_anim_ctrl.sv
// Fighter animation sequencer: picks the sprite animation code from commands and damage events.
module fighter_anim_ctrl
    import fighter_anim_pkg::*;
#(
    parameter int unsigned HOLD = HOLD_DEFAULT
)
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       left,
    input  logic       right,
    input  logic       crouch,
    input  logic       punch,
    input  logic       kick,
    input  logic       jump,
    input  logic       special,
    input  logic       hit,
    input  logic       ko,
    input  logic       round_reset,
    output logic [5:0] anim_code,
    output logic       step_strobe,
    output logic       attack_active,
    output logic       busy
);

    anim_state_t       state;
    anim_state_t       state_nxt;
    logic [ANIM_W-1:0] code_nxt;
    logic              clear_c;
    logic              step_c;
    logic              walk_c;

    assign walk_c = left ^ right;

    anim_step_timer #(.HOLD(HOLD)) u_timer (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .clear      (clear_c),
        .step_c     (step_c)
    );

    // Next state/code: immediate events first, then one advance per hold period
    always_comb begin
        state_nxt = state;
        code_nxt  = anim_code;
        clear_c   = 1'b0;
        if (round_reset) begin
            state_nxt = ST_IDLE;
            code_nxt  = A_START;
            clear_c   = 1'b1;
        end else if (ko) begin
            state_nxt = ST_KO;
            code_nxt  = A_KO_0;
            clear_c   = 1'b1;
        end else if (hit && (state != ST_KO) && (state != ST_SPECIAL) && (state != ST_HITSTUN)) begin
            state_nxt = ST_HITSTUN;
            code_nxt  = A_STUN_0;
            clear_c   = 1'b1;
        end else if (step_c) begin
            case (state)
                ST_IDLE, ST_WALK, ST_CROUCH: begin
                    if (special) begin
                        state_nxt = ST_SPECIAL;
                        code_nxt  = A_SPECIAL_0;
                    end else if (jump) begin
                        state_nxt = ST_JUMP;
                        code_nxt  = A_JUMP_0;
                    end else if (crouch && kick) begin
                        state_nxt = ST_CKICK;
                        code_nxt  = A_CKICK_0;
                    end else if (crouch) begin
                        state_nxt = ST_CROUCH;
                        code_nxt  = A_CROUCH;
                    end else if (kick) begin
                        state_nxt = ST_KICK;
                        code_nxt  = A_KICK_0;
                    end else if (punch) begin
                        state_nxt = ST_PUNCH;
                        code_nxt  = A_PUNCH_0;
                    end else if (walk_c) begin
                        state_nxt = ST_WALK;
                        if (state != ST_WALK) begin
                            code_nxt = A_WALK_IN;
                        end else if (anim_code == A_WALK_2) begin
                            code_nxt = A_WALK_0;
                        end else begin
                            code_nxt = anim_code + 6'd1;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                        if ((state == ST_IDLE) && (anim_code != A_IDLE_2)) begin
                            code_nxt = anim_code + 6'd1;
                        end else begin
                            code_nxt = A_IDLE_0;
                        end
                    end
                end
                ST_PUNCH, ST_KICK, ST_JUMP, ST_SPECIAL, ST_HITSTUN: begin
                    if ((anim_code == A_PUNCH_3) || (anim_code == A_KICK_3) ||
                        (anim_code == A_JUMP_4) || (anim_code == A_SPECIAL_3) ||
                        (anim_code == A_STUN_3)) begin
                        state_nxt = ST_IDLE;
                        code_nxt  = A_IDLE_0;
                    end else begin
                        code_nxt = anim_code + 6'd1;
                    end
                end
                ST_CKICK: begin
                    if (anim_code != A_CKICK_2) begin
                        code_nxt = anim_code + 6'd1;
                    end else if (crouch) begin
                        state_nxt = ST_CROUCH;
                        code_nxt  = A_CROUCH;
                    end else begin
                        state_nxt = ST_IDLE;
                        code_nxt  = A_IDLE_0;
                    end
                end
                ST_KO: begin
                    if (anim_code != A_KO_2) begin
                        code_nxt = anim_code + 6'd1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    code_nxt  = A_IDLE_0;
                end
            endcase
        end
    end

    // State, code and flags registered together so the flags line up with anim_code
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= ST_IDLE;
            anim_code     <= A_START;
            step_strobe   <= 1'b0;
            attack_active <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            anim_code     <= code_nxt;
            step_strobe   <= (code_nxt != anim_code);
            attack_active <= is_attack_code(code_nxt);
            busy          <= is_busy_state(state_nxt);
        end
    end

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Self-checking bench for fighter_anim_ctrl with HOLD=2.
module tb_fighter_anim_ctrl;

    localparam int unsigned HOLD = 2;

    // Input vector bit positions
    localparam logic [10:0] FT = 11'h400, LF = 11'h200, RT = 11'h100, CR = 11'h080;
    localparam logic [10:0] PU = 11'h040, KI = 11'h020, JU = 11'h010, SP = 11'h008;
    localparam logic [10:0] HI = 11'h004, KO = 11'h002, RR = 11'h001, NONE = 11'h000;

    localparam int M_IDLE = 0, M_WALK = 1, M_CROUCH = 2, M_PUNCH = 3, M_KICK = 4;
    localparam int M_CKICK = 5, M_JUMP = 6, M_SPECIAL = 7, M_STUN = 8, M_KO = 9;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick, left, right, crouch, punch, kick, jump, special;
    logic       hit, ko, round_reset;
    logic [5:0] anim_code;
    logic       step_strobe, attack_active, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current code, sequence of upcoming codes, tick count
    int m_code, m_prev, m_mode, m_ticks;
    int m_q[$];
    int seen[$];
    logic [10:0] rin;

    typedef struct {
        logic [10:0] in;
        int          code;
        int          strobe;
        int          att;
        int          bsy;
    } vec_t;
    vec_t tbl[18];

    fighter_anim_ctrl #(.HOLD(HOLD)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_tick    (frame_tick),
        .left          (left),
        .right         (right),
        .crouch        (crouch),
        .punch         (punch),
        .kick          (kick),
        .jump          (jump),
        .special       (special),
        .hit           (hit),
        .ko            (ko),
        .round_reset   (round_reset),
        .anim_code     (anim_code),
        .step_strobe   (step_strobe),
        .attack_active (attack_active),
        .busy          (busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_seq(input int md, input int first, input int len);
        m_mode = md;
        m_code = first;
        m_q.delete();
        for (int k = 1; k < len; k++) m_q.push_back(first + k);
    endtask

    task automatic m_rotate();
        int c;
        c = m_q.pop_front();
        m_q.push_back(c);
        m_code = c;
    endtask

    task automatic m_go_idle();
        m_mode = M_IDLE;
        m_code = 1;
        m_q.delete();
        m_q.push_back(2);
        m_q.push_back(3);
        m_q.push_back(1);
    endtask

    task automatic m_reset();
        m_ticks = 0;
        set_seq(M_IDLE, 0, 4);
        m_prev = 0;
    endtask

    task automatic m_advance(input logic [10:0] in);
        case (m_mode)
            M_IDLE, M_WALK, M_CROUCH: begin
                if (in[3])               set_seq(M_SPECIAL, 29, 4);
                else if (in[4])          set_seq(M_JUMP, 24, 5);
                else if (in[7] && in[5]) set_seq(M_CKICK, 21, 3);
                else if (in[7])          set_seq(M_CROUCH, 20, 1);
                else if (in[5])          set_seq(M_KICK, 16, 4);
                else if (in[6])          set_seq(M_PUNCH, 8, 4);
                else if (in[9] != in[8]) begin
                    if (m_mode == M_WALK) m_rotate();
                    else set_seq(M_WALK, 4, 4);
                end
                else if (m_mode == M_IDLE) m_rotate();
                else m_go_idle();
            end
            M_KO: if (m_q.size() > 0) m_code = m_q.pop_front();
            M_CKICK: begin
                if (m_q.size() > 0) m_code = m_q.pop_front();
                else if (in[7]) set_seq(M_CROUCH, 20, 1);
                else m_go_idle();
            end
            default: begin
                if (m_q.size() > 0) m_code = m_q.pop_front();
                else m_go_idle();
            end
        endcase
    endtask

    task automatic m_update(input logic [10:0] in);
        m_prev = m_code;
        if (in[0]) begin
            m_ticks = 0;
            set_seq(M_IDLE, 0, 4);
        end else if (in[1]) begin
            m_ticks = 0;
            set_seq(M_KO, 33, 3);
        end else if (in[2] && m_mode != M_KO && m_mode != M_SPECIAL && m_mode != M_STUN) begin
            m_ticks = 0;
            set_seq(M_STUN, 12, 4);
        end else if (in[10]) begin
            m_ticks++;
            if (m_ticks == int'(HOLD)) begin
                m_ticks = 0;
                m_advance(in);
            end
        end
    endtask

    function automatic int m_att(input int c);
        return (c == 10 || c == 18 || c == 22 || c == 31 || c == 32) ? 1 : 0;
    endfunction

    function automatic int m_busy(input int md);
        return (md == M_IDLE || md == M_WALK || md == M_CROUCH) ? 0 : 1;
    endfunction

    task automatic apply(input logic [10:0] in);
        {frame_tick, left, right, crouch, punch, kick, jump, special, hit, ko, round_reset} = in;
    endtask

    task automatic cycle(input logic [10:0] in);
        apply(in);
        @(posedge Clk);
        m_update(in);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " anim_code"}, int'(anim_code), m_code);
        chk({tag, " step_strobe"}, int'(step_strobe), (m_code != m_prev) ? 1 : 0);
        chk({tag, " attack_active"}, int'(attack_active), m_att(m_code));
        chk({tag, " busy"}, int'(busy), m_busy(m_mode));
    endtask

    task automatic run_collect(input logic [10:0] in, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            cycle(in);
            chk_model(tag);
            if (step_strobe) seen.push_back(int'(anim_code));
        end
    endtask

    initial begin
        // Reset state and idle/punch vectors
        tbl[0]  = '{FT,      0, 0, 0, 0};
        tbl[1]  = '{FT,      1, 1, 0, 0};
        tbl[2]  = '{FT,      1, 0, 0, 0};
        tbl[3]  = '{FT,      2, 1, 0, 0};
        tbl[4]  = '{FT,      2, 0, 0, 0};
        tbl[5]  = '{FT,      3, 1, 0, 0};
        tbl[6]  = '{FT,      3, 0, 0, 0};
        tbl[7]  = '{FT,      1, 1, 0, 0};
        tbl[8]  = '{FT | PU, 1, 0, 0, 0};
        tbl[9]  = '{FT | PU, 8, 1, 0, 1};
        tbl[10] = '{FT,      8, 0, 0, 1};
        tbl[11] = '{FT,      9, 1, 0, 1};
        tbl[12] = '{FT | LF, 9, 0, 0, 1};
        tbl[13] = '{FT | LF, 10, 1, 1, 1};
        tbl[14] = '{FT,      10, 0, 1, 1};
        tbl[15] = '{FT,      11, 1, 0, 1};
        tbl[16] = '{FT,      11, 0, 0, 1};
        tbl[17] = '{FT,      1, 1, 0, 0};

        apply(NONE);
        repeat (2) @(posedge Clk);
        #1;
        chk("reset anim_code", int'(anim_code), 0);
        chk("reset step_strobe", int'(step_strobe), 0);
        chk("reset attack_active", int'(attack_active), 0);
        chk("reset busy", int'(busy), 0);
        #2;
        Reset_n = 1'b1;
        m_reset();

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].in);
            chk($sformatf("tbl%0d anim_code", i), int'(anim_code), tbl[i].code);
            chk($sformatf("tbl%0d step_strobe", i), int'(step_strobe), tbl[i].strobe);
            chk($sformatf("tbl%0d attack_active", i), int'(attack_active), tbl[i].att);
            chk($sformatf("tbl%0d busy", i), int'(busy), tbl[i].bsy);
        end

        // Hit during kick code 17 with the hold counter mid-period
        for (int k = 0; k < 20 && m_code != 17; k++) begin
            cycle(FT | KI);
            chk_model("kick");
        end
        chk("kick reached 17", int'(anim_code), 17);
        cycle(FT);
        chk_model("kick mid");
        cycle(HI);
        chk("hit anim_code", int'(anim_code), 12);
        chk("hit step_strobe", int'(step_strobe), 1);
        chk("hit busy", int'(busy), 1);
        cycle(FT);
        chk("hit counter cleared", int'(anim_code), 12);
        seen.delete();
        run_collect(FT, 7, "stun");
        chk("stun changes", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("stun seq0", seen[0], 13);
            chk("stun seq1", seen[1], 14);
            chk("stun seq2", seen[2], 15);
            chk("stun seq3", seen[3], 1);
        end

        // ko and hit together during special code 30
        for (int k = 0; k < 20 && m_code != 30; k++) begin
            cycle(FT | SP);
            chk_model("special");
        end
        chk("special reached 30", int'(anim_code), 30);
        cycle(KO | HI);
        chk("ko anim_code", int'(anim_code), 33);
        chk("ko busy", int'(busy), 1);
        seen.delete();
        run_collect(FT, 4, "ko seq");
        chk("ko reached 35", int'(anim_code), 35);
        seen.delete();
        run_collect(FT, 40, "ko hold");
        chk("ko hold no changes", seen.size(), 0);
        chk("ko hold code", int'(anim_code), 35);
        cycle(RR);
        chk("round_reset anim_code", int'(anim_code), 0);
        chk("round_reset busy", int'(busy), 0);
        chk("round_reset step_strobe", int'(step_strobe), 1);

        // Crouch kick returning to crouch, then release to idle
        seen.delete();
        run_collect(FT | CR | KI, 2, "ckick");
        run_collect(FT | CR, 6, "ckick");
        run_collect(FT, 2, "ckick");
        chk("ckick changes", seen.size(), 5);
        if (seen.size() == 5) begin
            chk("ckick seq0", seen[0], 21);
            chk("ckick seq1", seen[1], 22);
            chk("ckick seq2", seen[2], 23);
            chk("ckick seq3", seen[3], 20);
            chk("ckick seq4", seen[4], 1);
        end

        // Asynchronous reset mid-jump at code 26
        for (int k = 0; k < 20 && m_code != 26; k++) begin
            cycle(FT | JU);
            chk_model("jump");
        end
        chk("jump reached 26", int'(anim_code), 26);
        chk("jump busy", int'(busy), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async reset anim_code", int'(anim_code), 0);
        chk("async reset step_strobe", int'(step_strobe), 0);
        chk("async reset attack_active", int'(attack_active), 0);
        chk("async reset busy", int'(busy), 0);
        m_reset();
        @(posedge Clk);
        #3;
        Reset_n = 1'b1;
        cycle(FT);
        chk("post reset one tick", int'(anim_code), 0);
        chk_model("post reset");
        cycle(FT);
        chk("post reset two ticks", int'(anim_code), 1);
        chk_model("post reset");

        // Randomized commands and events against the model
        for (int i = 0; i < 3000; i++) begin
            rin = NONE;
            rin[10] = ($urandom_range(0, 2) == 0);
            rin[9]  = ($urandom_range(0, 1) == 0);
            rin[8]  = ($urandom_range(0, 1) == 0);
            rin[7]  = ($urandom_range(0, 4) == 0);
            rin[6]  = ($urandom_range(0, 5) == 0);
            rin[5]  = ($urandom_range(0, 5) == 0);
            rin[4]  = ($urandom_range(0, 9) == 0);
            rin[3]  = ($urandom_range(0, 11) == 0);
            rin[2]  = ($urandom_range(0, 29) == 0);
            rin[1]  = ($urandom_range(0, 249) == 0);
            rin[0]  = ($urandom_range(0, 149) == 0);
            cycle(rin);
            chk_model("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
